// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one pipelined 16/8 divider with a credit-guarded response FIFO; optional DIVARB_STATS_EN adds err_cnt/stats_clr
module div_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int LAT       = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DIVARB_STATS_EN
  input  logic                 stats_clr,
  output logic [15:0]          err_cnt,
`endif
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          div_a,
  output logic [7:0]           div_b,
  input  logic [7:0]           div_q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_q,
  output logic                 rsp_dz,
  output logic                 rsp_ovf,
  output logic                 busy
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           dz;
    logic           ovf;
  } sh_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           dz;
    logic           ovf;
    logic [7:0]     q;
  } ent_t;

  sh_t            sh [LAT+1];
  ent_t           mem [RSP_DEPTH];
  ent_t           head;
  logic [IDW-1:0] ptr, gid;
  logic [CW-1:0]  credit, cnt;
  logic [AW-1:0]  wr, rd;
  logic           grant_en, found, accept, push, pop;
  logic [15:0]    sel_a;
  logic [7:0]     sel_b;

  // Round-robin search from ptr+1, gated by registered credit so a same-cycle pop never widens the window
  always_comb begin
    grant_en = (credit < CW'(RSP_DEPTH)) && rst_n;
    found = 1'b0;
    gid = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] j;
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gid = j;
      end
    end
    accept = grant_en && found;
    req_ready = '0;
    req_ready[gid] = accept;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gid == IDW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  assign push      = sh[LAT].v;
  assign pop       = rsp_valid && rsp_ready;
  assign head      = mem[rd];
  assign rsp_valid = cnt != '0;
  assign rsp_id    = rsp_valid ? head.id : '0;
  assign rsp_q     = rsp_valid ? head.q : '0;
  assign rsp_dz    = rsp_valid && head.dz;
  assign rsp_ovf   = rsp_valid && head.ovf;
  assign busy      = credit != '0;

  // Issue operands and walk the tag/flag shadow alongside the divider; credit tracks accepted-but-unpopped work
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      div_a <= '0;
      div_b <= '0;
      credit <= '0;
      for (int i = 0; i <= LAT; i++) sh[i] <= '0;
    end else begin
      if (accept) ptr <= gid;
      div_a <= accept ? sel_a : '0;
      div_b <= accept ? sel_b : '0;
      sh[0] <= accept ? {1'b1, gid, sel_b == 8'd0, sel_b != 8'd0 && sel_a[15:8] >= sel_b} : '0;
      for (int i = 1; i <= LAT; i++) sh[i] <= sh[i-1];
      credit <= credit + CW'(accept) - CW'(pop);
    end
  end

  // Response storage; the divider result is replaced by all-ones whenever it is meaningless
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= {sh[LAT].id, sh[LAT].dz, sh[LAT].ovf, (sh[LAT].dz || sh[LAT].ovf) ? 8'hFF : div_q};
  end

  // Circular FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= (wr == AW'(RSP_DEPTH - 1)) ? '0 : wr + 1'b1;
      if (pop) rd <= (rd == AW'(RSP_DEPTH - 1)) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef DIVARB_STATS_EN
  // Saturating count of popped responses carrying an error flag; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) err_cnt <= '0;
    else if (pop && (rsp_dz || rsp_ovf) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
